// File: rtl/ucie_fdi_rx_pkg.sv
// Shared types and constants for the UCIe FDI receive flit endpoint.
package ucie_fdi_rx_pkg;

    function automatic int vc_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int FLIT_WIDTH = 256;
    localparam int NUM_VCS    = 8;
    localparam int VC_W       = vc_width(NUM_VCS);

    localparam logic [15:0] CANCEL_CNT_MAX = 16'hFFFF;

    typedef struct packed {
        logic [FLIT_WIDTH-1:0] data;
        logic                  sop;
        logic                  eop;
        logic [3:0]            be;
        logic [VC_W-1:0]       vc;
    } fdi_rx_beat_t;

endpackage

// File: rtl/ucie_fdi_rx_fifo.sv
// First-word-fall-through FIFO of receive beats with wrap-bit pointers and an occupancy count.
module ucie_fdi_rx_fifo
    import ucie_fdi_rx_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fdi_rx_beat_t wr_beat,
    input  logic         pop,
    output fdi_rx_beat_t rd_beat,
    output logic         empty,
    output logic [AW:0]  count
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    fdi_rx_beat_t mem_r [DEPTH];
    logic [AW:0]  wr_ptr_r;
    logic [AW:0]  rd_ptr_r;
    logic         full_s;
    logic         push_ok_s;
    logic         pop_ok_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign count     = wr_ptr_r - rd_ptr_r;
    assign push_ok_s = push & ~full_s;
    assign pop_ok_s  = pop & ~empty;
    assign rd_beat   = mem_r[rd_ptr_r[AW-1:0]];

    // Storage array; cleared on reset so the head beat reads as zero while empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_beat;
        end
    end

    // Read and write pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/ucie_fdi_rx_flit_receiver.sv
// FDI receive flit endpoint: one-cycle cancel hold stage, shared FWFT buffer, per-VC credit return.
// Optional cancel statistics counter enabled by defining UCIE_FDI_RX_STATS_EN.
module ucie_fdi_rx_flit_receiver
    import ucie_fdi_rx_pkg::*;
#(
    parameter int DEPTH = 16
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_flit_valid,
    output logic                  rx_flit_ready,
    input  logic [FLIT_WIDTH-1:0] rx_flit_data,
    input  logic                  rx_flit_sop,
    input  logic                  rx_flit_eop,
    input  logic [3:0]            rx_flit_be,
    input  logic [VC_W-1:0]       rx_flit_vc,
    input  logic                  rx_flit_cancel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FLIT_WIDTH-1:0] out_data,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic [3:0]            out_be,
    output logic [VC_W-1:0]       out_vc,
    output logic [NUM_VCS-1:0]    credit_return,
    output logic                  cancel_err,
    output logic [15:0]           cancel_count
);

    localparam int          AW      = $clog2(DEPTH);
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    fdi_rx_beat_t         in_beat_s;
    fdi_rx_beat_t         hold_r;
    logic                 hold_v_r;
    fdi_rx_beat_t         fifo_rd_s;
    logic                 fifo_empty_s;
    logic [AW:0]          fifo_count_s;
    logic [AW:0]          occupancy_s;
    logic                 accept_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 cancel_drop_s;
    logic                 cancel_err_r;
    logic [CW-1:0]        pending_r     [NUM_VCS];
    logic [CW-1:0]        pending_nxt_s [NUM_VCS];
    logic [1:0]           inc_s         [NUM_VCS];
    logic [NUM_VCS-1:0]   credit_nxt_s;
    logic [NUM_VCS-1:0]   credit_return_r;

    assign in_beat_s = '{data: rx_flit_data, sop: rx_flit_sop, eop: rx_flit_eop,
                         be: rx_flit_be, vc: rx_flit_vc};

    // The held beat counts against capacity so a non-cancelled beat always has a slot.
    assign occupancy_s   = fifo_count_s + {{AW{1'b0}}, hold_v_r};
    assign rx_flit_ready = (occupancy_s < DEPTH_L);
    assign accept_s      = rx_flit_valid & rx_flit_ready;
    assign cancel_drop_s = hold_v_r & rx_flit_cancel;
    assign push_s        = hold_v_r & ~rx_flit_cancel;
    assign pop_s         = out_valid & out_ready;

    // Hold stage: every accepted beat waits here exactly one cycle for a possible cancel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_v_r <= 1'b0;
            hold_r   <= '0;
        end else begin
            hold_v_r <= accept_s;
            if (accept_s) begin
                hold_r <= in_beat_s;
            end
        end
    end

    // Cancel protocol error flag: cancel arrived with nothing to cancel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cancel_err_r <= 1'b0;
        end else begin
            cancel_err_r <= rx_flit_cancel & ~hold_v_r;
        end
    end

    ucie_fdi_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_s),
        .wr_beat (hold_r),
        .pop     (pop_s),
        .rd_beat (fifo_rd_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    assign out_valid = ~fifo_empty_s;
    assign out_data  = fifo_rd_s.data;
    assign out_sop   = fifo_rd_s.sop;
    assign out_eop   = fifo_rd_s.eop;
    assign out_be    = fifo_rd_s.be;
    assign out_vc    = fifo_rd_s.vc;

    // Per-VC credit bookkeeping: a VC can gain two credits (pop + cancel) but returns one per cycle.
    always_comb begin
        credit_nxt_s = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            inc_s[v] = {1'b0, pop_s && (fifo_rd_s.vc == VC_W'(v))}
                     + {1'b0, cancel_drop_s && (hold_r.vc == VC_W'(v))};
            credit_nxt_s[v] = (pending_r[v] != '0);
            pending_nxt_s[v] = pending_r[v] + {{(CW-2){1'b0}}, inc_s[v]}
                             - {{(CW-1){1'b0}}, credit_nxt_s[v]};
        end
    end

    // Pending credit counters and registered credit pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                pending_r[v] <= '0;
            end
            credit_return_r <= '0;
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                pending_r[v] <= pending_nxt_s[v];
            end
            credit_return_r <= credit_nxt_s;
        end
    end

    assign credit_return = credit_return_r;
    assign cancel_err    = cancel_err_r;

`ifdef UCIE_FDI_RX_STATS_EN
    logic [15:0] cancel_count_r;

    // Saturating count of beats dropped by cancel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cancel_count_r <= 16'h0000;
        end else if (cancel_drop_s && (cancel_count_r != CANCEL_CNT_MAX)) begin
            cancel_count_r <= cancel_count_r + 16'h0001;
        end
    end

    assign cancel_count = cancel_count_r;
`else
    assign cancel_count = 16'h0000;
`endif

endmodule

// File: tb/tb_ucie_fdi_rx_flit_receiver.sv
// Directed self-checking bench for ucie_fdi_rx_flit_receiver (default and UCIE_FDI_RX_STATS_EN builds).
module tb_ucie_fdi_rx_flit_receiver;

    logic         clk;
    logic         reset;
    logic         rx_flit_valid;
    logic         rx_flit_ready;
    logic [255:0] rx_flit_data;
    logic         rx_flit_sop;
    logic         rx_flit_eop;
    logic [3:0]   rx_flit_be;
    logic [2:0]   rx_flit_vc;
    logic         rx_flit_cancel;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_data;
    logic         out_sop;
    logic         out_eop;
    logic [3:0]   out_be;
    logic [2:0]   out_vc;
    logic [7:0]   credit_return;
    logic         cancel_err;
    logic [15:0]  cancel_count;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_cancels = 0;

    ucie_fdi_rx_flit_receiver dut (
        .clk(clk), .reset(reset),
        .rx_flit_valid(rx_flit_valid), .rx_flit_ready(rx_flit_ready),
        .rx_flit_data(rx_flit_data), .rx_flit_sop(rx_flit_sop), .rx_flit_eop(rx_flit_eop),
        .rx_flit_be(rx_flit_be), .rx_flit_vc(rx_flit_vc), .rx_flit_cancel(rx_flit_cancel),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop), .out_be(out_be), .out_vc(out_vc),
        .credit_return(credit_return), .cancel_err(cancel_err), .cancel_count(cancel_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] mk(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 ^ i;
        return {8{w}};
    endfunction

    function automatic logic [15:0] exp_cc(input int n);
`ifdef UCIE_FDI_RX_STATS_EN
        return (n > 65535) ? 16'hFFFF : n[15:0];
`else
        return (n < 0) ? 16'hFFFF : 16'h0000;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int i, input int vc);
        logic [31:0] iv;
        logic [31:0] vv;
        iv = i;
        vv = vc;
        rx_flit_valid = 1'b1;
        rx_flit_data  = mk(i);
        rx_flit_sop   = iv[0];
        rx_flit_eop   = ~iv[0];
        rx_flit_be    = iv[3:0];
        rx_flit_vc    = vv[2:0];
    endtask

    task automatic idle(input int n);
        rx_flit_valid  = 1'b0;
        rx_flit_cancel = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx_flit_valid = 1'b0; rx_flit_data = '0; rx_flit_sop = 1'b0; rx_flit_eop = 1'b0;
        rx_flit_be = 4'h0; rx_flit_vc = 3'd0; rx_flit_cancel = 1'b0; out_ready = 1'b0;
        repeat (2) tick();
        n_checks++; if (rx_flit_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", rx_flit_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (credit_return !== 8'h00) $display("FAIL rst_credit: got %h want 00", credit_return); else n_pass++;
        n_checks++; if (cancel_err !== 1'b0) $display("FAIL rst_cancel_err: got %b want 0", cancel_err); else n_pass++;
        n_checks++; if (cancel_count !== 16'h0000) $display("FAIL rst_cancel_count: got %h want 0000", cancel_count); else n_pass++;
        n_checks++; if (out_data !== 256'h0) $display("FAIL rst_out_data: got %h want 0", out_data); else n_pass++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        set_beat(100, 3);
        rx_flit_sop = 1'b1; rx_flit_eop = 1'b1; rx_flit_be = 4'hA;
        tick();
        rx_flit_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL t1_early_valid: got %b want 0", out_valid); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b1) $display("FAIL t1_valid: got %b want 1", out_valid); else n_pass++;
        n_checks++; if (out_data !== mk(100)) $display("FAIL t1_data: got %h want %h", out_data, mk(100)); else n_pass++;
        n_checks++; if ({out_sop, out_eop, out_be, out_vc} !== {1'b1, 1'b1, 4'hA, 3'd3})
            $display("FAIL t1_fields: got %b%b %h %0d want 11 a 3", out_sop, out_eop, out_be, out_vc); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL t1_popped: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (credit_return !== 8'h00) $display("FAIL t1_credit_early: got %h want 00", credit_return); else n_pass++;
        tick();
        n_checks++; if (credit_return !== 8'h08) $display("FAIL t1_credit: got %h want 08", credit_return); else n_pass++;
        tick();
        n_checks++; if (credit_return !== 8'h00) $display("FAIL t1_credit_end: got %h want 00", credit_return); else n_pass++;
        idle(2);
    endtask

    task automatic test_cancel();
        out_ready = 1'b1;
        set_beat(150, 5);
        tick();
        rx_flit_valid = 1'b0;
        rx_flit_cancel = 1'b1;
        tick();
        rx_flit_cancel = 1'b0;
        exp_cancels++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL t2_no_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (cancel_err !== 1'b0) $display("FAIL t2_no_err: got %b want 0", cancel_err); else n_pass++;
        tick();
        n_checks++; if (credit_return !== 8'h20) $display("FAIL t2_credit: got %h want 20", credit_return); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL t2_no_valid2: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (cancel_count !== exp_cc(exp_cancels))
            $display("FAIL t2_cancel_count: got %h want %h", cancel_count, exp_cc(exp_cancels)); else n_pass++;
        tick();
        n_checks++; if (credit_return !== 8'h00) $display("FAIL t2_credit_once: got %h want 00", credit_return); else n_pass++;
        idle(2);
    endtask

    task automatic test_cancel_err();
        rx_flit_cancel = 1'b1;
        tick();
        rx_flit_cancel = 1'b0;
        n_checks++; if (cancel_err !== 1'b1) $display("FAIL t5_err: got %b want 1", cancel_err); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL t5_fifo: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (rx_flit_ready !== 1'b1) $display("FAIL t5_ready: got %b want 1", rx_flit_ready); else n_pass++;
        tick();
        n_checks++; if (cancel_err !== 1'b0) $display("FAIL t5_err_pulse: got %b want 0", cancel_err); else n_pass++;
        n_checks++; if (credit_return !== 8'h00) $display("FAIL t5_credit: got %h want 00", credit_return); else n_pass++;
        n_checks++; if (cancel_count !== exp_cc(exp_cancels))
            $display("FAIL t5_cancel_count: got %h want %h", cancel_count, exp_cc(exp_cancels)); else n_pass++;
        idle(2);
    endtask

    task automatic test_cancel_pop();
        out_ready = 1'b0;
        set_beat(400, 2);
        tick();
        set_beat(401, 2);
        tick();
        rx_flit_valid = 1'b0;
        rx_flit_cancel = 1'b1;
        out_ready = 1'b1;
        tick();
        rx_flit_cancel = 1'b0;
        out_ready = 1'b0;
        exp_cancels++;
        n_checks++; if (credit_return !== 8'h00) $display("FAIL t4_credit0: got %h want 00", credit_return); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL t4_empty: got %b want 0", out_valid); else n_pass++;
        tick();
        n_checks++; if (credit_return !== 8'h04) $display("FAIL t4_credit1: got %h want 04", credit_return); else n_pass++;
        tick();
        n_checks++; if (credit_return !== 8'h04) $display("FAIL t4_credit2: got %h want 04", credit_return); else n_pass++;
        tick();
        n_checks++; if (credit_return !== 8'h00) $display("FAIL t4_credit3: got %h want 00", credit_return); else n_pass++;
        n_checks++; if (cancel_count !== exp_cc(exp_cancels))
            $display("FAIL t4_cancel_count: got %h want %h", cancel_count, exp_cc(exp_cancels)); else n_pass++;
        idle(2);
    endtask

    task automatic test_full();
        int creds;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            set_beat(200 + i, i % 8);
            tick();
            n_checks++; if (rx_flit_ready !== (i < 15))
                $display("FAIL t3_ready_%0d: got %b want %b", i, rx_flit_ready, (i < 15)); else n_pass++;
        end
        rx_flit_valid = 1'b0;
        tick();
        n_checks++; if (rx_flit_ready !== 1'b0) $display("FAIL t3_full_ready: got %b want 0", rx_flit_ready); else n_pass++;
        n_checks++; if (out_data !== mk(200)) $display("FAIL t3_head: got %h want %h", out_data, mk(200)); else n_pass++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++; if (rx_flit_ready !== 1'b1) $display("FAIL t3_drain1_ready: got %b want 1", rx_flit_ready); else n_pass++;
        creds = 0;
        out_ready = 1'b1;
        for (int k = 1; k < 16; k++) begin
            n_checks++; if (out_valid !== 1'b1 || out_data !== mk(200 + k))
                $display("FAIL t3_order_%0d: got %b %h want 1 %h", k, out_valid, out_data, mk(200 + k)); else n_pass++;
            creds += $countones(credit_return);
            tick();
        end
        out_ready = 1'b0;
        repeat (20) begin
            creds += $countones(credit_return);
            tick();
        end
        n_checks++; if (out_valid !== 1'b0) $display("FAIL t3_drained: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (creds != 16) $display("FAIL t3_credits: got %0d want 16", creds); else n_pass++;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            if (t <= 8) set_beat(300 + t - 1, (t - 1) % 8);
            else rx_flit_valid = 1'b0;
            tick();
            n_checks++; if (out_valid !== (t >= 2 && t <= 9))
                $display("FAIL b2b_valid_%0d: got %b want %b", t, out_valid, (t >= 2 && t <= 9)); else n_pass++;
            if (t >= 2 && t <= 9) begin
                n_checks++; if (out_data !== mk(300 + t - 2))
                    $display("FAIL b2b_data_%0d: got %h want %h", t, out_data, mk(300 + t - 2)); else n_pass++;
            end
        end
        out_ready = 1'b0;
        idle(20);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_beat(500 + i, 1);
            tick();
        end
        rx_flit_valid = 1'b0;
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++; if (out_data !== mk(501)) $display("FAIL t6_pre_head: got %h want %h", out_data, mk(501)); else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL t6_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (credit_return !== 8'h00) $display("FAIL t6_credit: got %h want 00", credit_return); else n_pass++;
        n_checks++; if (rx_flit_ready !== 1'b1) $display("FAIL t6_ready: got %b want 1", rx_flit_ready); else n_pass++;
        n_checks++; if (cancel_count !== 16'h0000) $display("FAIL t6_cc: got %h want 0000", cancel_count); else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_cancels = 0;
        tick();
        tick();
        n_checks++; if (credit_return !== 8'h00) $display("FAIL t6_no_credit: got %h want 00", credit_return); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL t6_stay_empty: got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_stats();
        int n;
        int errs;
`ifdef UCIE_FDI_RX_STATS_EN
        n = 70000;
`else
        n = 20;
`endif
        errs = 0;
        out_ready = 1'b0;
        set_beat(600, 4);
        tick();
        rx_flit_cancel = 1'b1;
        repeat (n) begin
            tick();
            errs += int'(cancel_err);
        end
        rx_flit_valid = 1'b0;
        rx_flit_cancel = 1'b0;
        exp_cancels += n;
        tick();
        n_checks++; if (errs != 0) $display("FAIL ts_errs: got %0d want 0", errs); else n_pass++;
        n_checks++; if (cancel_count !== exp_cc(exp_cancels))
            $display("FAIL ts_cancel_count: got %h want %h", cancel_count, exp_cc(exp_cancels)); else n_pass++;
        n_checks++; if (out_valid !== 1'b1 || out_data !== mk(600))
            $display("FAIL ts_survivor: got %b %h want 1 %h", out_valid, out_data, mk(600)); else n_pass++;
        out_ready = 1'b1;
        idle(10);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL ts_drained: got %b want 0", out_valid); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_cancel();
        test_cancel_err();
        test_cancel_pop();
        test_full();
        test_back_to_back();
        test_reset_mid();
        test_stats();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
